// File: rtl/gtpblkfifo.sv
// GTP block FIFO: packs CW-delimited 16-bit blocks into 32-bit words and exposes only complete blocks.
// Optional saturating drop statistics are enabled with `define GTPBLKFIFO_STAT_EN.
module gtpblkfifo #(
   parameter int MBITS = 13,
   parameter int LBITS = 9
) (
   input  logic             gtp_clk,
   input  logic             rst_n,
   input  logic [15:0]      gtp_dat,
   input  logic             gtp_vld,
   input  logic             give,
   output logic [31:0]      data,
   output logic             have,
   output logic             missed,
   output logic             trunc,
   output logic [MBITS-1:0] used
`ifdef GTPBLKFIFO_STAT_EN
   ,
   input  logic             cnt_clr,
   output logic [15:0]      missed_cnt,
   output logic [15:0]      trunc_cnt
`endif
);

   localparam int DEPTH = 1 << MBITS;
   localparam int AW    = ((MBITS > LBITS) ? MBITS : LBITS) + 1;

   typedef enum logic {IDLE = 1'b0, BODY = 1'b1} state_t;

   state_t           state;
   logic [MBITS-1:0] waddr, waddrb, waddrb_d, raddr;
   logic [15:0]      hold;
   logic [LBITS-1:0] blk_len, body_cnt;
   logic [31:0]      mem [DEPTH];
   logic [31:0]      data_q;

   logic             is_cw, last_body;
   logic [LBITS-1:0] cw_len;
   logic [MBITS-1:0] base, occ, raddr_nx, waddr_nx, waddrb_nx, wr_addr;
   logic [AW-1:0]    need, free;
   logic [31:0]      wr_word;
   logic             wr_en, drop, cut, start;

   assign is_cw    = gtp_dat[15];
   assign cw_len   = gtp_dat[LBITS-1:0];
   // Readers only see blocks through the delayed commit pointer.
   assign have     = give & (raddr != waddrb_d);
   assign raddr_nx = raddr + MBITS'(have);
   assign data     = have ? data_q : 32'h0;

   always_comb begin
      // A CW arriving mid-block is judged against the space left after the rewind.
      base      = (state == BODY && is_cw) ? waddrb : waddr;
      occ       = base - raddr;
      need      = AW'(cw_len[LBITS-1:1]) + AW'(1);
      free      = AW'(DEPTH - 1) - AW'(occ);
      last_body = (body_cnt + LBITS'(1)) == blk_len;
      wr_en     = 1'b0;
      wr_addr   = waddr;
      wr_word   = {16'h8000, gtp_dat};
      waddr_nx  = waddr;
      waddrb_nx = waddrb;
      drop      = 1'b0;
      cut       = 1'b0;
      start     = 1'b0;
      if (gtp_vld) begin
         if (state == BODY && !is_cw) begin
            if (!body_cnt[0]) begin
               wr_en   = 1'b1;
               wr_word = {gtp_dat, hold};
            end else if (last_body) begin
               wr_en   = 1'b1;
            end
            if (wr_en)
               waddr_nx = waddr + MBITS'(1);
            if (last_body)
               waddrb_nx = waddr_nx;
         end else if (is_cw) begin
            cut      = (state == BODY);
            waddr_nx = base;
            if (need > free) begin
               drop = 1'b1;
            end else if (cw_len == '0) begin
               wr_en     = 1'b1;
               wr_addr   = base;
               waddr_nx  = base + MBITS'(1);
               waddrb_nx = waddr_nx;
            end else begin
               start = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge gtp_clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         waddr    <= '0;
         waddrb   <= '0;
         waddrb_d <= '0;
         raddr    <= '0;
         used     <= '0;
         hold     <= '0;
         blk_len  <= '0;
         body_cnt <= '0;
         missed   <= 1'b0;
         trunc    <= 1'b0;
      end else begin
         waddr    <= waddr_nx;
         waddrb   <= waddrb_nx;
         waddrb_d <= waddrb;
         raddr    <= raddr_nx;
         used     <= waddr_nx - raddr_nx;
         missed   <= drop;
         // A truncation that also drops the new block reports only the drop.
         trunc    <= cut & ~drop;
         if (gtp_vld) begin
            hold <= gtp_dat;
            if (start) begin
               state    <= BODY;
               blk_len  <= cw_len;
               body_cnt <= '0;
            end else if (state == BODY) begin
               if (is_cw || last_body)
                  state <= IDLE;
               body_cnt <= body_cnt + LBITS'(1);
            end
         end
      end
   end

   always_ff @(posedge gtp_clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_word;
      data_q <= mem[raddr_nx];
   end

`ifdef GTPBLKFIFO_STAT_EN
   always_ff @(posedge gtp_clk or negedge rst_n) begin
      if (!rst_n) begin
         missed_cnt <= '0;
         trunc_cnt  <= '0;
      end else if (cnt_clr) begin
         missed_cnt <= '0;
         trunc_cnt  <= '0;
      end else begin
         if (missed && missed_cnt != 16'hFFFF)
            missed_cnt <= missed_cnt + 16'd1;
         if (trunc && trunc_cnt != 16'hFFFF)
            trunc_cnt <= trunc_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_gtpblkfifo.sv
// Bench for gtpblkfifo: queue-based block model feeding a scoreboard, with a negedge monitor
// that pops and compares every word the DUT hands out.
`timescale 1ns/1ps
module tb_gtpblkfifo;
   localparam int MBITS = 4;
   localparam int LBITS = 9;
   localparam int DEPTH = 16;

   logic             gtp_clk = 1'b0;
   logic             rst_n   = 1'b0;
   logic [15:0]      gtp_dat = '0;
   logic             gtp_vld = 1'b0;
   logic             give    = 1'b0;
   logic [31:0]      data;
   logic             have, missed, trunc;
   logic [MBITS-1:0] used;
`ifdef GTPBLKFIFO_STAT_EN
   logic             cnt_clr = 1'b0;
   logic [15:0]      missed_cnt, trunc_cnt;
   int               m_mcnt = 0;
   int               m_tcnt = 0;
`endif

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic [31:0] exp_q[$];
   logic [15:0] body[$];
   logic [15:0] blk_cw;
   int          blk_len, blk_start;
   bit          in_blk      = 0;
   int          m_wr        = 0;
   int          rd_count    = 0;
   bit          exp_missed  = 0;
   bit          exp_trunc   = 0;

   localparam logic [15:0] A = 16'h1111, B = 16'h2222, C = 16'h3333, X = 16'h0ABC;

   always #5 gtp_clk = ~gtp_clk;

   gtpblkfifo #(.MBITS(MBITS), .LBITS(LBITS)) dut (
      .gtp_clk (gtp_clk),
      .rst_n   (rst_n),
      .gtp_dat (gtp_dat),
      .gtp_vld (gtp_vld),
      .give    (give),
      .data    (data),
      .have    (have),
      .missed  (missed),
      .trunc   (trunc),
      .used    (used)
`ifdef GTPBLKFIFO_STAT_EN
      ,
      .cnt_clr    (cnt_clr),
      .missed_cnt (missed_cnt),
      .trunc_cnt  (trunc_cnt)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Block-level model: one call per accepted input half-word.
   task automatic model_word(input logic [15:0] d);
      int l, n, free;
      logic [15:0] h[$];
      logic [15:0] lo, hi;
      if (in_blk && !d[15]) begin
         body.push_back(d);
         if (body.size() == blk_len) begin
            h = body;
            h.push_front(blk_cw);
            n = blk_len / 2 + 1;
            for (int i = 0; i < n; i++) begin
               lo = h[2*i];
               hi = (2*i + 1 < h.size()) ? h[2*i+1] : 16'h8000;
               exp_q.push_back({hi, lo});
            end
            m_wr   = blk_start + n;
            in_blk = 0;
         end else begin
            m_wr = blk_start + (body.size() + 1) / 2;
         end
      end else if (d[15]) begin
         if (in_blk) begin
            exp_trunc = 1;
            m_wr      = blk_start;
            in_blk    = 0;
         end
         l    = int'(d[LBITS-1:0]);
         n    = l / 2 + 1;
         free = DEPTH - 1 - (m_wr - rd_count);
         if (n > free) begin
            exp_missed = 1;
            exp_trunc  = 0;
         end else if (l == 0) begin
            exp_q.push_back({16'h8000, d});
            m_wr++;
         end else begin
            in_blk    = 1;
            blk_len   = l;
            blk_start = m_wr;
            blk_cw    = d;
            body.delete();
         end
`ifdef GTPBLKFIFO_STAT_EN
         if (exp_missed && m_mcnt < 65535) m_mcnt++;
         if (exp_trunc && m_tcnt < 65535) m_tcnt++;
`endif
      end
   endtask

   // One clock: check registered outputs of the previous edge, then drive new inputs.
   task automatic step(input logic v, input logic [15:0] d, input logic g);
      @(posedge gtp_clk);
      #1;
      chk("used", 32'(used), 32'((m_wr - rd_count) % DEPTH));
      chk("missed", 32'(missed), 32'(exp_missed));
      chk("trunc", 32'(trunc), 32'(exp_trunc));
      exp_missed = 0;
      exp_trunc  = 0;
      gtp_vld = v;
      gtp_dat = d;
      give    = g;
      if (v) model_word(d);
   endtask

   task automatic drain();
      for (int i = 0; i < 64 && exp_q.size() > 0; i++) step(1'b0, 16'h0, 1'b1);
      step(1'b0, 16'h0, 1'b0);
      step(1'b0, 16'h0, 1'b0);
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      @(posedge gtp_clk);
      #1;
      rst_n   = 1'b0;
      gtp_vld = 1'b0;
      give    = 1'b1;
      #2;
      chk("rst_data", data, 32'h0);
      chk("rst_have", 32'(have), 32'd0);
      chk("rst_missed", 32'(missed), 32'd0);
      chk("rst_trunc", 32'(trunc), 32'd0);
      chk("rst_used", 32'(used), 32'd0);
      exp_q.delete();
      body.delete();
      in_blk     = 0;
      m_wr       = 0;
      rd_count   = 0;
      exp_missed = 0;
      exp_trunc  = 0;
`ifdef GTPBLKFIFO_STAT_EN
      chk("rst_missed_cnt", 32'(missed_cnt), 32'd0);
      chk("rst_trunc_cnt", 32'(trunc_cnt), 32'd0);
      m_mcnt = 0;
      m_tcnt = 0;
`endif
      @(posedge gtp_clk);
      #1;
      rst_n = 1'b1;
      give  = 1'b0;
   endtask

   task automatic send_block(input int l);
      step(1'b1, 16'h8000 | 16'(l), 1'b0);
      for (int j = 0; j < l; j++) step(1'b1, 16'($urandom_range(0, 32767)), 1'b0);
   endtask

   // Monitor: every word handed out must be the next expected one.
   always @(negedge gtp_clk) begin
      if (rst_n) begin
         if (have) begin
            if (exp_q.size() == 0) begin
               failures++;
               checks++;
               $display("FAIL spurious_have: got have=1 expected no committed data at %0t", $time);
            end else begin
               chk("data", data, exp_q.pop_front());
            end
            rd_count++;
         end else begin
            chk("data_zero", data, 32'h0);
         end
         if (!give) chk("have_nogive", 32'(have), 32'd0);
      end
   end

   initial begin
      logic v, g;
      logic [15:0] d;
      do_reset();

      // L=3: two words, commit visibility and explicit word values
      step(1'b1, 16'h8003, 1'b0);
      step(1'b1, A, 1'b0);
      step(1'b1, B, 1'b0);
      step(1'b1, C, 1'b0);
      step(1'b0, 16'h0, 1'b1);
      @(negedge gtp_clk);
      chk("have_early", 32'(have), 32'd0);
      step(1'b0, 16'h0, 1'b1);
      @(negedge gtp_clk);
      chk("have_ready", 32'(have), 32'd1);
      chk("t1_word0", data, {A, 16'h8003});
      step(1'b0, 16'h0, 1'b1);
      @(negedge gtp_clk);
      chk("t1_word1", data, {C, B});
      drain();

      // even L and L=0
      step(1'b1, 16'h8002, 1'b0);
      step(1'b1, A, 1'b0);
      step(1'b1, B, 1'b0);
      step(1'b1, 16'h8000, 1'b0);
      drain();

      // exact fill to 15 words, then a dropped block with ignored body
      for (int b = 0; b < 5; b++) send_block(5);
      step(1'b0, 16'h0, 1'b0);
      chk("full_used", 32'(used), 32'd15);
      step(1'b1, 16'h8001, 1'b0);
      step(1'b1, X, 1'b0);
      step(1'b0, 16'h0, 1'b0);
      drain();

      // truncation and rewind
      step(1'b1, 16'h8005, 1'b0);
      step(1'b1, A, 1'b0);
      step(1'b1, B, 1'b0);
      step(1'b1, 16'h8001, 1'b0);
      step(1'b1, X, 1'b0);
      drain();

      // wrap: bring read pointer to 14 then write blocks across the end of memory
      for (int i = 0; i < 16 && (rd_count % DEPTH) != 14; i++) begin
         step(1'b1, 16'h8000, 1'b0);
         drain();
      end
      chk("raddr_at_14", 32'(rd_count % DEPTH), 32'd14);
      for (int b = 0; b < 3; b++) send_block(7);
      drain();

      // reset in the middle of a block
      step(1'b1, 16'h8005, 1'b0);
      step(1'b1, A, 1'b0);
      step(1'b1, B, 1'b0);
      do_reset();
      step(1'b0, 16'h0, 1'b1);
      step(1'b0, 16'h0, 1'b1);
      step(1'b0, 16'h0, 1'b0);

      // random traffic with concurrent reads
      for (int i = 0; i < 4000; i++) begin
         v = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 3) == 0)
            d = 16'h8000 | 16'(($urandom_range(0, 15) == 0) ? $urandom_range(13, 28) : $urandom_range(0, 11));
         else
            d = 16'($urandom_range(0, 32767));
         g = 1'($urandom_range(0, 1));
         step(v, d, g);
      end
      step(1'b0, 16'h0, 1'b0);
      drain();

`ifdef GTPBLKFIFO_STAT_EN
      for (int b = 0; b < 5; b++) send_block(5);
      for (int i = 0; i < 70000; i++) step(1'b1, 16'h8001, 1'b0);
      step(1'b0, 16'h0, 1'b0);
      step(1'b0, 16'h0, 1'b0);
      step(1'b0, 16'h0, 1'b0);
      chk("missed_cnt_sat", 32'(missed_cnt), 32'h0000FFFF);
      chk("missed_cnt_model", 32'(missed_cnt), 32'(m_mcnt));
      chk("trunc_cnt_model", 32'(trunc_cnt), 32'(m_tcnt));
      cnt_clr = 1'b1;
      step(1'b0, 16'h0, 1'b0);
      cnt_clr = 1'b0;
      m_mcnt  = 0;
      m_tcnt  = 0;
      step(1'b0, 16'h0, 1'b0);
      chk("missed_cnt_clr", 32'(missed_cnt), 32'd0);
      chk("trunc_cnt_clr", 32'(trunc_cnt), 32'd0);
      drain();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/gtpblkfifo.md
# gtpblkfifo

Parametrised successor of the GTP block FIFO: accepts a 16-bit word stream from one GTP receiver, assembles control-word (CW) delimited blocks into 32-bit words and stores only complete blocks. Blocks are offered to the readout arbiter one 32-bit word per `give`. Over the previous generation it adds:
- generic length-field width;
- truncated-block detection and rewind;
- an occupancy output;
- a data bus that is always driven;
- a 2-cycle commit-to-read safety margin;
- optional drop statistics.

## Interface
- MBITS, 13: log2 of FIFO depth in 32-bit words; usable capacity is 2^MBITS-1 words.
- LBITS, 9: width of the CW length field L. Channel field width is 15-LBITS. Allowed range 2..12.
- gtp_clk  in  1  single clock for write and read sides.
- rst_n  in  1  asynchronous, active-low reset.
- gtp_dat  in  16  input word; bit 15 set marks a CW: {1, channel[14-LBITS:0], L[LBITS-1:0]}.
- gtp_vld  in  1  gtp_dat valid this cycle.
- give  in  1  arbiter requests one 32-bit word.
- data  out  32  FIFO head word; driven 0 when `have`=0.
- have  out  1  combinational: `give` & committed data present; `data` is valid in the same cycle.
- missed  out  1  one-cycle pulse: block dropped for lack of space.
- trunc  out  1  one-cycle pulse: partial block discarded.
- used  out  MBITS  registered: waddr-raddr, including any uncommitted partial block.
- cnt_clr  in  1  synchronous clear of statistics counters (only with GTPBLKFIFO_STAT_EN).
- missed_cnt, trunc_cnt  out  16 each  saturating drop counters (only with GTPBLKFIFO_STAT_EN).

## Operation
- Block size: a block is L 16-bit body words after the CW, L+1 half-words in total. It occupies N = L[LBITS-1:1]+1 32-bit words. Arithmetic is MBITS wide, zero-extended.
- Packing: the earlier half-word goes in bits [15:0]. If L is even, the final word is {16'h8000, last}.
- States: IDLE, BODY. Only cycles with gtp_vld=1 advance the FSM.
- IDLE, non-CW word: ignored.
- IDLE, CW, free = 2^MBITS-1-(waddr-raddr):
  - N > free: pulse `missed`, stay IDLE.
  - L=0: write {16'h8000, CW}, commit, stay IDLE.
  - Otherwise: hold the CW as the even half, go to BODY.
- BODY, non-CW word: pack with the held half and write on each odd half. Commit after the L-th body word, setting waddrb to the new waddr, then return to IDLE.
- BODY, CW before the block completes:
  - pulse `trunc`;
  - rewind waddr to waddrb, discarding the partial block;
  - process the new CW exactly as in IDLE, in the same cycle.
- Read: each cycle with `have`=1 advances raddr by 1. The arbiter counts words itself, using L from the head CW.
- Read and write in the same cycle are legal. `used` reflects both.

## Timing
- Reset (rst_n low, asynchronous): waddr=waddrb=raddr=0, state IDLE, `missed`=`trunc`=0, `used`=0, `data`=0, counters 0. Reset mid-block discards the partial block.
- Write latency: a 32-bit word is written at the clock edge that accepts its odd half.
- Commit visibility: the reader uses waddrb_d, i.e. waddrb delayed one clock. `have` can first assert 2 cycles after the edge that writes the final word. This avoids read-during-write on the prefetch register.
- Read prefetch: the data register loads fifo[raddr+give] every clock, so `data` follows `have` with zero added latency. Back-to-back `give` streams one word per clock.
- Empty: raddr==waddrb_d gives `have`=0, and raddr holds even with `give`=1.
- Full: acceptance only needs N ≤ free, so an exact fit is accepted. Pointers wrap modulo 2^MBITS.
- `missed` and `trunc` are registered and asserted in the cycle after the offending CW. They never assert together.

## Configuration
- GTPBLKFIFO_STAT_EN defined:
  - missed_cnt and trunc_cnt increment on each pulse and saturate at 16'hFFFF;
  - cnt_clr zeroes them;
  - a simultaneous pulse with cnt_clr yields 0.
- Undefined: the counter and cnt_clr ports and their logic are absent. All other behaviour is identical.

## Test plan
- MBITS=4, CW 16'h8003 (L=3) + 3 words A,B,C -> 2 words {A,8003},{C,B}; `have` 2 cycles after the last write; `used` 2→0 after two `give`.
- CW 16'h8002 (L=2) + A,B -> {A,8002},{8000,B}; CW 16'h8000 -> single word {8000,8000}.
- MBITS=4, 15 words occupied, then CW with L=1 (N=1) -> `missed` pulse, block not written, following body words ignored.
- CW L=5, 2 body words, then CW L=1 + X -> `trunc` pulse, `used` returns to the pre-block value, second block {X,8001} read correctly.
- Fill to raddr=14, with blocks wrapping past address 15 -> data intact across wrap; rst_n pulse mid-block -> all outputs 0, FIFO empty.
- With GTPBLKFIFO_STAT_EN: 70000 forced drops -> missed_cnt=FFFF; cnt_clr -> 0.
